// File: rtl/aftab_serial_comparator_if.sv
// Request/result bundle for the slice-serial magnitude comparator.
// Requester drives operands and start; comparator returns ready/done and flags.
// Flags are registered in the comparator and hold until the next done.
interface aftab_serial_comparator_if #(
  parameter int SIZE = 32
);
  logic            startCompare;
  logic            compareSignedUnsignedBar;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            ready;
  logic            done;
  logic            lt;
  logic            eq;
  logic            gt;

  modport master (
    output startCompare, compareSignedUnsignedBar, a, b,
    input  ready, done, lt, eq, gt
  );

  modport slave (
    input  startCompare, compareSignedUnsignedBar, a, b,
    output ready, done, lt, eq, gt
  );
endinterface

// File: rtl/aftab_serial_comparator.sv
// Slice-serial signed/unsigned magnitude comparator, MSB slice first.
// Latency: NSLICE cycles, or NSLICE-i with AFTAB_SERCMP_EARLY_EXIT_EN (i = first differing slice).
// Backpressure: one request at a time; startCompare is ignored while ready=0 and never queued.
module aftab_serial_comparator #(
  parameter int SIZE  = 32,
  parameter int SLICE = 8
) (
  input logic                     clk,
  input logic                     rst,
  aftab_serial_comparator_if.slave cmp
);

  localparam int NSLICE = SIZE / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] TOP = IW'(NSLICE - 1);

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            decided;
  logic            dec_lt;
  logic            mode;
  logic [SIZE-1:0] a_q;
  logic [SIZE-1:0] b_q;
  logic            ready_q;
  logic            done_q;
  logic            lt_q;
  logic            eq_q;
  logic            gt_q;

  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic             s_lt;
  logic             s_gt;
  logic             diff;
  logic             exit_now;
  logic             res_lt;
  logic             res_eq;
  logic             res_gt;

  assign cmp.ready = ready_q;
  assign cmp.done  = done_q;
  assign cmp.lt    = lt_q;
  assign cmp.eq    = eq_q;
  assign cmp.gt    = gt_q;

  // Current slice compare; flipping the sign bit of the top slice maps
  // two's-complement ordering onto unsigned ordering.
  always_comb begin
    sa = a_q[int'(idx)*SLICE +: SLICE];
    sb = b_q[int'(idx)*SLICE +: SLICE];
    if (mode && (idx == TOP)) begin
      sa[SLICE-1] = ~sa[SLICE-1];
      sb[SLICE-1] = ~sb[SLICE-1];
    end
    s_lt = (sa < sb);
    s_gt = (sa > sb);
    diff = s_lt | s_gt;
`ifdef AFTAB_SERCMP_EARLY_EXIT_EN
    exit_now = diff || (idx == '0);
`else
    exit_now = (idx == '0);
`endif
    // An earlier decision wins over anything seen in lower slices.
    res_lt = 1'b0;
    res_eq = 1'b0;
    res_gt = 1'b0;
    if (decided) begin
      res_lt = dec_lt;
      res_gt = ~dec_lt;
    end else if (diff) begin
      res_lt = s_lt;
      res_gt = s_gt;
    end else begin
      res_eq = 1'b1;
    end
  end

  // Control FSM with registered ready/done/flags; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      idx     <= '0;
      decided <= 1'b0;
      dec_lt  <= 1'b0;
      mode    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmp.startCompare) begin
            a_q     <= cmp.a;
            b_q     <= cmp.b;
            mode    <= cmp.compareSignedUnsignedBar;
            idx     <= TOP;
            decided <= 1'b0;
            ready_q <= 1'b0;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          if (!decided && diff) begin
            decided <= 1'b1;
            dec_lt  <= s_lt;
          end
          if (exit_now) begin
            lt_q    <= res_lt;
            eq_q    <= res_eq;
            gt_q    <= res_gt;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aftab_serial_comparator.sv
// Scoreboard bench for aftab_serial_comparator (SIZE=32, SLICE=8).
// Expected flags and done cycle are queued at accept; a negedge monitor checks them.
// Also checks flag hold between results, reset abort and handshake rules.
module tb_aftab_serial_comparator;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  typedef struct {
    logic [2:0] f;
    int         due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   last_done_cyc;
  logic [2:0] hold;
  exp_t q[$];

  aftab_serial_comparator_if #(.SIZE(32)) bus ();

  aftab_serial_comparator #(.SIZE(32), .SLICE(8)) dut (
    .clk (clk),
    .rst (rst),
    .cmp (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected latency from accept to done for first differing slice i.
  function automatic int lat(input int i);
`ifdef AFTAB_SERCMP_EARLY_EXIT_EN
    return 4 - i;
`else
    return 4;
`endif
  endfunction

  // Monitor: pops on done, otherwise checks that flags hold.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold = 3'b000;
    end else if (bus.done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("flags", 32'({bus.lt, bus.eq, bus.gt}), 32'(e.f));
        chk("done_cycle", 32'(cyc), 32'(e.due));
        chk("ready_on_done", 32'(bus.ready), 32'd1);
        hold = e.f;
        last_done_cyc = cyc;
      end
    end else begin
      chk("flags_hold", 32'({bus.lt, bus.eq, bus.gt}), 32'(hold));
    end
  end

  task automatic do_req(input logic [31:0] av, input logic [31:0] bv, input logic sg,
                        input logic [2:0] f, input int n, input bit b2b);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ready) begin
      chk("ready_timeout", 32'(bus.ready), 32'd1);
      return;
    end
    bus.a = av;
    bus.b = bv;
    bus.compareSignedUnsignedBar = sg;
    bus.startCompare = 1'b1;
    @(posedge clk);
    #1;
    bus.startCompare = 1'b0;
    if (b2b) chk("b2b_accept", 32'(cyc), 32'(last_done_cyc + 1));
    q.push_back('{f, cyc + n});
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) chk("missing_done", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    last_done_cyc = 0;
    hold = 3'b000;
    rst = 1'b1;
    bus.startCompare = 1'b0;
    bus.compareSignedUnsignedBar = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_flags", 32'({bus.lt, bus.eq, bus.gt}), 32'd0);

    // Directed vectors; each after the first is issued in the previous done cycle
    do_req(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, GT, lat(3), 1'b0);
    do_req(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, LT, lat(3), 1'b1);
    do_req(32'h1234_5678, 32'h1234_5678, 1'b0, EQ, lat(0), 1'b1);
    do_req(32'h1234_5678, 32'h1234_5678, 1'b1, EQ, lat(0), 1'b1);
    do_req(32'h0000_0001, 32'h0000_0002, 1'b0, LT, lat(0), 1'b1);
    do_req(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, LT, lat(3), 1'b1);
    do_req(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, GT, lat(3), 1'b1);
    do_req(32'h0000_0100, 32'h0000_0200, 1'b1, LT, lat(1), 1'b1);
    do_req(32'h0000_0300, 32'h0000_0200, 1'b0, GT, lat(1), 1'b1);
    wait_idle();

    // Start pulsed while busy with different operands is ignored
    do_req(32'h0000_0001, 32'h0000_0002, 1'b0, LT, lat(0), 1'b0);
    bus.a = 32'hFFFF_FFFF;
    bus.b = 32'h0000_0000;
    bus.compareSignedUnsignedBar = 1'b0;
    bus.startCompare = 1'b1;
    @(posedge clk);
    #1 bus.startCompare = 1'b0;
    wait_idle();

    // Reset on the second COMPARE cycle aborts without done
    do_req(32'h0000_0001, 32'h0000_0002, 1'b0, LT, lat(0), 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_flags", 32'({bus.lt, bus.eq, bus.gt}), 32'd0);

    // Fresh request after reset
    do_req(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, GT, lat(3), 1'b0);
    do_req(32'hABCD_0000, 32'hABCD_0000, 1'b0, EQ, lat(0), 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
